// File: rtl/load_store_sequencer_pkg.sv
// Shared opcode, ALU and state encodings for the load/store control sequencer.
// Also holds the opcode classifier and the packed datapath control bundle.
package load_store_sequencer_pkg;

    localparam logic [4:0] OP_LDW  = 5'b00000;
    localparam logic [4:0] OP_LDWI = 5'b00001;
    localparam logic [4:0] OP_STW  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;
    localparam logic [3:0] S_FAULT = 4'd10;

    typedef enum logic [2:0] {
        CLS_LDW,
        CLS_LDWI,
        CLS_STW,
        CLS_ADDI,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic pc_out;
        logic inc_pc;
        logic mar_in;
        logic pc_in;
        logic read;
        logic write;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in_low;
        logic z_low_out;
        logic c_out;
        logic ba_out;
        logic gra;
        logic grb;
        logic r_in;
        logic r_out;
    } ctrl_t;

    function automatic op_class_e decode_op(input logic [4:0] opc);
        case (opc)
            OP_LDW:  decode_op = CLS_LDW;
            OP_LDWI: decode_op = CLS_LDWI;
            OP_STW:  decode_op = CLS_STW;
            OP_ADDI: decode_op = CLS_ADDI;
            OP_NOP:  decode_op = CLS_NOP;
            OP_HALT: decode_op = CLS_HALT;
            default: decode_op = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/load_store_sequencer_if.sv
// Sequencer <-> datapath/memory bundle: opcode and mem_ready in, datapath controls and status out.
// master is the sequencer side, slave is the datapath/memory side.
interface load_store_sequencer_if #(
    parameter int OPW = 5
);
    logic           run_in;
    logic [OPW-1:0] ir_opcode;
    logic           mem_ready;

    logic PCout, IncPC, MARin, PCin, Read, Write, MDRin, MDRout, IRin;
    logic Yin, Zin_low, Zlowout, Cout, BAout, Gra, Grb, Rin, Rout;

    logic [4:0] alu_op;
    logic [3:0] tstate;
    logic       running;
    logic       halted;
    logic       fault;
    logic       illegal_op;

    modport master (
        input  run_in, ir_opcode, mem_ready,
        output PCout, IncPC, MARin, PCin, Read, Write, MDRin, MDRout, IRin,
        output Yin, Zin_low, Zlowout, Cout, BAout, Gra, Grb, Rin, Rout,
        output alu_op, tstate, running, halted, fault, illegal_op
    );

    modport slave (
        output run_in, ir_opcode, mem_ready,
        input  PCout, IncPC, MARin, PCin, Read, Write, MDRin, MDRout, IRin,
        input  Yin, Zin_low, Zlowout, Cout, BAout, Gra, Grb, Rin, Rout,
        input  alu_op, tstate, running, halted, fault, illegal_op
    );

endinterface

// File: rtl/load_store_sequencer.sv
// Hardwired T-state sequencer: fetch, ldw/ldwi/stw/addi/nop/halt, controls decoded from registered state.
// Memory phases stall on mem_ready for up to MEM_TIMEOUT cycles, then fall into an absorbing FAULT.
module load_store_sequencer
    import load_store_sequencer_pkg::*;
#(
    parameter int OPW         = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNTW        = 4
) (
    input  logic                   Clock,
    input  logic                   clear,
    load_store_sequencer_if.master bus
);

    logic [3:0]      state_q, state_d;
    logic [OPW-1:0]  op_q;
    logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;
    op_class_e       cls;
    logic            mem_wait;
    ctrl_t           ctl;
    logic [4:0]      alu_sel;
    logic            illegal;

    // The opcode is live on the IR bus during T3 and held in op_q afterwards.
    assign cls = decode_op(5'((state_q == S_T3) ? bus.ir_opcode : op_q));

    assign mem_wait = (state_q == S_T1)
                   || (state_q == S_T6 && cls == CLS_LDW)
                   || (state_q == S_T7 && cls == CLS_STW);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            S_IDLE:  if (bus.run_in) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (bus.mem_ready) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (cls)
                    CLS_HALT:             state_d = S_HALT;
                    CLS_NOP, CLS_ILLEGAL: state_d = S_T0;
                    default:              state_d = S_T4;
                endcase
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (cls == CLS_LDW || cls == CLS_STW) ? S_T6 : S_T0;
            S_T6: begin
                if (cls != CLS_LDW || bus.mem_ready) state_d = S_T7;
            end
            S_T7: begin
                if (cls != CLS_STW || bus.mem_ready) state_d = S_T0;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        // Counter is zero whenever a wait state is entered, so index 0 marks the first wait cycle.
        if (mem_wait && !bus.mem_ready) begin
            if (wait_cnt_q == CNTW'(MEM_TIMEOUT - 1)) begin
                state_d = S_FAULT;
            end else begin
                wait_cnt_d = wait_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == S_T3) op_q <= bus.ir_opcode;
        end
    end

    always_comb begin
        ctl     = '0;
        alu_sel = ALU_NONE;
        illegal = 1'b0;
        case (state_q)
            S_T0: begin
                ctl.pc_out   = 1'b1;
                ctl.mar_in   = 1'b1;
                ctl.inc_pc   = 1'b1;
                ctl.z_in_low = 1'b1;
            end
            S_T1: begin
                ctl.z_low_out = 1'b1;
                ctl.pc_in     = (wait_cnt_q == '0);
                ctl.read      = 1'b1;
                ctl.mdr_in    = 1'b1;
            end
            S_T2: begin
                ctl.mdr_out = 1'b1;
                ctl.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_LDW, CLS_LDWI, CLS_STW: begin
                        ctl.grb    = 1'b1;
                        ctl.ba_out = 1'b1;
                        ctl.y_in   = 1'b1;
                    end
                    CLS_ADDI: begin
                        ctl.grb   = 1'b1;
                        ctl.r_out = 1'b1;
                        ctl.y_in  = 1'b1;
                    end
                    CLS_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                ctl.c_out    = 1'b1;
                ctl.z_in_low = 1'b1;
                alu_sel      = ALU_ADD;
            end
            S_T5: begin
                ctl.z_low_out = 1'b1;
                if (cls == CLS_LDW || cls == CLS_STW) begin
                    ctl.mar_in = 1'b1;
                end else begin
                    ctl.gra  = 1'b1;
                    ctl.r_in = 1'b1;
                end
            end
            S_T6: begin
                ctl.mdr_in = 1'b1;
                if (cls == CLS_LDW) begin
                    ctl.read = 1'b1;
                end else begin
                    ctl.gra   = 1'b1;
                    ctl.r_out = 1'b1;
                end
            end
            S_T7: begin
                if (cls == CLS_LDW) begin
                    ctl.mdr_out = 1'b1;
                    ctl.gra     = 1'b1;
                    ctl.r_in    = 1'b1;
                end else begin
                    ctl.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.PCout   = ctl.pc_out;
    assign bus.IncPC   = ctl.inc_pc;
    assign bus.MARin   = ctl.mar_in;
    assign bus.PCin    = ctl.pc_in;
    assign bus.Read    = ctl.read;
    assign bus.Write   = ctl.write;
    assign bus.MDRin   = ctl.mdr_in;
    assign bus.MDRout  = ctl.mdr_out;
    assign bus.IRin    = ctl.ir_in;
    assign bus.Yin     = ctl.y_in;
    assign bus.Zin_low = ctl.z_in_low;
    assign bus.Zlowout = ctl.z_low_out;
    assign bus.Cout    = ctl.c_out;
    assign bus.BAout   = ctl.ba_out;
    assign bus.Gra     = ctl.gra;
    assign bus.Grb     = ctl.grb;
    assign bus.Rin     = ctl.r_in;
    assign bus.Rout    = ctl.r_out;

    assign bus.alu_op     = alu_sel;
    assign bus.illegal_op = illegal;
    assign bus.tstate     = state_q;
    assign bus.running    = (state_q >= S_T0) && (state_q <= S_T7);
    assign bus.halted     = (state_q == S_HALT);
    assign bus.fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_load_store_sequencer.sv
// Randomised bench: a trace model expands each instruction into its expected per-cycle
// (tstate, controls) sequence; the driver replays it and a negedge monitor scores the DUT.
module tb_load_store_sequencer;

    localparam int MEM_TIMEOUT = 15;

    localparam logic [4:0] OPC_LDW  = 5'b00000;
    localparam logic [4:0] OPC_LDWI = 5'b00001;
    localparam logic [4:0] OPC_STW  = 5'b00010;
    localparam logic [4:0] OPC_ADDI = 5'b01011;
    localparam logic [4:0] OPC_NOP  = 5'b11001;
    localparam logic [4:0] OPC_HALT = 5'b11010;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3, ST_T3 = 4'd4;
    localparam logic [3:0] ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7, ST_T7 = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9, ST_FAULT = 4'd10;

    localparam logic [26:0] M_PCOUT  = 27'h1 << 0;
    localparam logic [26:0] M_INCPC  = 27'h1 << 1;
    localparam logic [26:0] M_MARIN  = 27'h1 << 2;
    localparam logic [26:0] M_PCIN   = 27'h1 << 3;
    localparam logic [26:0] M_READ   = 27'h1 << 4;
    localparam logic [26:0] M_WRITE  = 27'h1 << 5;
    localparam logic [26:0] M_MDRIN  = 27'h1 << 6;
    localparam logic [26:0] M_MDROUT = 27'h1 << 7;
    localparam logic [26:0] M_IRIN   = 27'h1 << 8;
    localparam logic [26:0] M_YIN    = 27'h1 << 9;
    localparam logic [26:0] M_ZIN    = 27'h1 << 10;
    localparam logic [26:0] M_ZLO    = 27'h1 << 11;
    localparam logic [26:0] M_COUT   = 27'h1 << 12;
    localparam logic [26:0] M_BA     = 27'h1 << 13;
    localparam logic [26:0] M_GRA    = 27'h1 << 14;
    localparam logic [26:0] M_GRB    = 27'h1 << 15;
    localparam logic [26:0] M_RIN    = 27'h1 << 16;
    localparam logic [26:0] M_ROUT   = 27'h1 << 17;
    localparam logic [26:0] M_RUN    = 27'h1 << 18;
    localparam logic [26:0] M_HLT    = 27'h1 << 19;
    localparam logic [26:0] M_FLT    = 27'h1 << 20;
    localparam logic [26:0] M_ILL    = 27'h1 << 21;
    localparam logic [26:0] M_ADD    = 27'h3 << 22;

    typedef struct {
        logic        run;
        logic        mrdy;
        logic [4:0]  opc;
        logic        abort;
        logic [3:0]  st;
        logic [26:0] ctl;
    } cyc_t;

    typedef struct {
        logic [3:0]  st;
        logic [26:0] ctl;
    } exp_t;

    logic Clock;
    logic clear;
    cyc_t plan[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    load_store_sequencer_if #(.OPW(5)) bus();

    load_store_sequencer #(.OPW(5), .MEM_TIMEOUT(MEM_TIMEOUT), .CNTW(4)) dut (
        .Clock(Clock),
        .clear(clear),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    logic [26:0] obs_w;
    assign obs_w = {bus.alu_op, bus.illegal_op, bus.fault, bus.halted, bus.running,
                    bus.Rout, bus.Rin, bus.Grb, bus.Gra, bus.BAout, bus.Cout, bus.Zlowout,
                    bus.Zin_low, bus.Yin, bus.IRin, bus.MDRout, bus.MDRin, bus.Write,
                    bus.Read, bus.PCin, bus.MARin, bus.IncPC, bus.PCout};

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    function automatic logic [4:0] rnd_opc();
        return 5'($urandom);
    endfunction

    function automatic int rnd_delay();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 7) return MEM_TIMEOUT - 1;
        return int'($urandom_range(0, 3));
    endfunction

    function automatic logic [4:0] rnd_op();
        logic [4:0] o;
        int k;
        k = int'($urandom_range(0, 5));
        case (k)
            0: o = OPC_LDW;
            1: o = OPC_LDWI;
            2: o = OPC_STW;
            3: o = OPC_ADDI;
            4: o = OPC_NOP;
            default: begin
                o = rnd_opc();
                while (o inside {OPC_LDW, OPC_LDWI, OPC_STW, OPC_ADDI, OPC_NOP, OPC_HALT})
                    o = rnd_opc();
            end
        endcase
        return o;
    endfunction

    function automatic void emit(input logic [3:0] st, input logic [26:0] ctl, input logic mrdy,
                                 input logic [4:0] opc, input logic run, input logic ab);
        cyc_t c;
        c.run = run; c.mrdy = mrdy; c.opc = opc; c.abort = ab; c.st = st; c.ctl = ctl;
        plan.push_back(c);
    endfunction

    function automatic void emit_r(input logic [3:0] st, input logic [26:0] ctl);
        emit(st, ctl, rnd_bit(), rnd_opc(), rnd_bit(), 1'b0);
    endfunction

    // Memory phase: d cycles without mem_ready then one with it; a delay past the
    // timeout yields MEM_TIMEOUT stalled cycles followed by the absorbing fault state.
    function automatic bit wait_phase(input logic [3:0] st, input logic [26:0] base,
                                      input logic [26:0] first, input int d, input int abort_at);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            emit(st, base | ((i == 0) ? first : 27'h0), (i == d), rnd_opc(), rnd_bit(), (i == abort_at));
            if (i == abort_at) return 1'b1;
            if (i == d) return 1'b0;
        end
        for (int k = 0; k < 3; k++) emit_r(ST_FAULT, M_FLT);
        return 1'b1;
    endfunction

    function automatic bit gen_instr(input logic [4:0] op, input int d1, input int d6,
                                     input int d7, input int ab6);
        logic [26:0] t3;
        emit_r(ST_T0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
        if (wait_phase(ST_T1, M_ZLO | M_READ | M_MDRIN | M_RUN, M_PCIN, d1, -1)) return 1'b1;
        emit_r(ST_T2, M_MDROUT | M_IRIN | M_RUN);
        case (op)
            OPC_LDW, OPC_LDWI, OPC_STW: t3 = M_GRB | M_BA | M_YIN | M_RUN;
            OPC_ADDI:                   t3 = M_GRB | M_ROUT | M_YIN | M_RUN;
            OPC_NOP, OPC_HALT:          t3 = M_RUN;
            default:                    t3 = M_RUN | M_ILL;
        endcase
        emit(ST_T3, t3, rnd_bit(), op, rnd_bit(), 1'b0);
        if (op == OPC_HALT) begin
            for (int k = 0; k < 4; k++) emit(ST_HALT, M_HLT, rnd_bit(), rnd_opc(), k[0], 1'b0);
            return 1'b1;
        end
        if (!(op inside {OPC_LDW, OPC_LDWI, OPC_STW, OPC_ADDI})) return 1'b0;
        emit_r(ST_T4, M_COUT | M_ADD | M_ZIN | M_RUN);
        if (op == OPC_LDWI || op == OPC_ADDI) begin
            emit_r(ST_T5, M_ZLO | M_GRA | M_RIN | M_RUN);
            return 1'b0;
        end
        emit_r(ST_T5, M_ZLO | M_MARIN | M_RUN);
        if (op == OPC_LDW) begin
            if (wait_phase(ST_T6, M_READ | M_MDRIN | M_RUN, 27'h0, d6, ab6)) return 1'b1;
            emit_r(ST_T7, M_MDROUT | M_GRA | M_RIN | M_RUN);
            return 1'b0;
        end
        emit_r(ST_T6, M_GRA | M_ROUT | M_MDRIN | M_RUN);
        return wait_phase(ST_T7, M_WRITE | M_RUN, 27'h0, d7, -1);
    endfunction

    task automatic chk_direct(input string name);
        checks++;
        if (bus.tstate !== ST_IDLE || obs_w !== 27'h0) begin
            errors++;
            $display("FAIL %s t=%0t tstate=%0d ctl=%h expected tstate=0 ctl=0", name, $time, bus.tstate, obs_w);
        end
    endtask

    task automatic do_reset();
        @(posedge Clock);
        #3 clear = 1'b0;
        #1 chk_direct("reset_state");
    endtask

    task automatic run_plan();
        cyc_t c;
        exp_t e;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(posedge Clock);
            #1;
            clear         = 1'b1;
            bus.run_in    = c.run;
            bus.mem_ready = c.mrdy;
            bus.ir_opcode = c.opc;
            if (c.abort) begin
                #2 clear = 1'b0;
                #1 chk_direct("clear_mid_instr");
            end else begin
                e.st = c.st;
                e.ctl = c.ctl;
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_plan();
        plan.delete();
        repeat ($urandom_range(0, 2)) emit(ST_IDLE, 27'h0, rnd_bit(), rnd_opc(), 1'b0, 1'b0);
        emit(ST_IDLE, 27'h0, rnd_bit(), rnd_opc(), 1'b1, 1'b0);
    endtask

    task automatic session(input int n, input int kind);
        bit term;
        int w, big, d;
        term = 1'b0;
        start_plan();
        for (int i = 0; i < n && !term; i++)
            term = gen_instr(rnd_op(), rnd_delay(), rnd_delay(), rnd_delay(), -1);
        if (!term) begin
            case (kind)
                0: term = gen_instr(OPC_HALT, rnd_delay(), 0, 0, -1);
                1: begin
                    w   = int'($urandom_range(0, 2));
                    big = int'($urandom_range(MEM_TIMEOUT, MEM_TIMEOUT + 5));
                    if (w == 0)      term = gen_instr(OPC_LDWI, big, 0, 0, -1);
                    else if (w == 1) term = gen_instr(OPC_LDW, rnd_delay(), big, 0, -1);
                    else             term = gen_instr(OPC_STW, rnd_delay(), 0, big, -1);
                end
                default: begin
                    d    = int'($urandom_range(0, 4));
                    term = gen_instr(OPC_LDW, rnd_delay(), d, 0, int'($urandom_range(0, d)));
                end
            endcase
        end
        do_reset();
        run_plan();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.tstate !== e.st || obs_w !== e.ctl) begin
                    errors++;
                    $display("FAIL cycle_trace t=%0t tstate=%0d ctl=%h expected tstate=%0d ctl=%h",
                             $time, bus.tstate, obs_w, e.st, e.ctl);
                end
            end
        end
    end

    initial begin
        bit t;
        Clock         = 1'b0;
        clear         = 1'b1;
        bus.run_in    = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir_opcode = 5'b0;

        // Directed: ldwi, ldw with a 2-cycle T6 stall, stw, then halt.
        start_plan();
        t = gen_instr(OPC_LDWI, 0, 0, 0, -1);
        t = gen_instr(OPC_LDW, 0, 2, 0, -1);
        t = gen_instr(OPC_STW, 0, 0, 0, -1);
        t = gen_instr(OPC_HALT, 0, 0, 0, -1);
        do_reset();
        run_plan();

        // Directed: illegal opcode, then T1 timeout into FAULT.
        start_plan();
        t = gen_instr(5'b11111, 0, 0, 0, -1);
        t = gen_instr(OPC_LDWI, MEM_TIMEOUT + 2, 0, 0, -1);
        do_reset();
        run_plan();

        // Directed: clear during the T6 stall of an ldw, then a fresh run.
        start_plan();
        t = gen_instr(OPC_LDW, 0, 3, 0, 1);
        do_reset();
        run_plan();

        for (int s = 0; s < 12; s++) session(int'($urandom_range(3, 8)), s % 3);

        @(posedge Clock);
        @(negedge Clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Hardwired control sequencer for the 32-bit datapath.
- Replaces hand-driven T-state stimulus with an FSM covering:
  - instruction fetch;
  - ldw, ldwi, stw, addi, nop and halt;
  - variable-latency memory through a mem_ready handshake, with a timeout fault.
- Sits between the IR opcode field and the datapath control inputs.

Parameters:
- OPW, 5: opcode width; matches the IR opcode field.
- MEM_TIMEOUT, 15: maximum cycles to wait for mem_ready before entering FAULT.
- CNTW, 4: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- run_in  in  1  start request; sampled only in IDLE.
- ir_opcode  in  OPW  IR opcode field; valid from T3 of each instruction.
- mem_ready  in  1  memory completion for the current Read/Write.
- PCout, IncPC, MARin, PCin, Read, Write, MDRin, MDRout, IRin, Yin, Zin_low, Zlowout, Cout, BAout, Gra, Grb, Rin, Rout  out  1 each  datapath controls.
- alu_op  out  5  ALU select: 00011 (ADD) in T4, else 00000.
- tstate  out  4  current state encoding, for debug.
- running  out  1  high in T0..T7.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.

Behaviour:
- Reset: clear low forces IDLE asynchronously. All outputs are 0, op_q=0 and wait_cnt=0, mid-instruction included.
- Outputs are decoded from registered state and op_q. From T3 they also use ir_opcode.
- Opcodes (package): ldw=00000, ldwi=00001, stw=00010, addi=01011, nop=11001, halt=11010.
- IDLE: go to T0 when run_in=1.
- T0: PCout, MARin, IncPC, Zin_low. Next: T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 until mem_ready=1, then T2.
  - PCin is asserted only in the first T1 cycle.
- T2: MDRout, IRin. Next: T3.
- T3, decoded from ir_opcode; op_q captured at the end of T3:
  - ldw, ldwi, stw: Grb, BAout, Yin.
  - addi: Grb, Rout, Yin.
  - nop: no controls; next T0.
  - halt: next HALT.
  - other opcode: illegal_op pulse; next T0.
- T4: Cout, alu_op=ADD, Zin_low. Next: T5.
- T5:
  - ldwi, addi: Zlowout, Gra, Rin; next T0.
  - ldw, stw: Zlowout, MARin; next T6.
- T6:
  - ldw: Read, MDRin; wait for mem_ready, then T7.
  - stw: Gra, Rout, MDRin for one cycle; next T7.
- T7:
  - ldw: MDRout, Gra, Rin for one cycle; next T0.
  - stw: Write; wait for mem_ready, then T0.
- Memory waits (T1, ldw T6, stw T7):
  - wait_cnt clears on entry and increments every cycle mem_ready=0.
  - Reaching MEM_TIMEOUT without mem_ready enters FAULT.
  - mem_ready on the first cycle gives zero extra cycles.
- Completion:
  - No pending instruction. Returning to T0 fetches the next instruction regardless of run_in.
  - run_in is ignored outside IDLE.
- HALT and FAULT: absorbing. All controls 0, halted/fault high. Exit only via clear.
- tstate encoding: IDLE=0, T0..T7=1..8, HALT=9, FAULT=10.

Decomposition:
- Shared package contains:
  - opcode constants;
  - ALU op constants (ADD=00011);
  - state encoding localparams.
- No sub-module is needed. The wait counter is inline, and the FSM and output decode sit in one module.

Test Plan:
- clear low, then high, run_in=1; mem_ready tied high; ir_opcode=00001 (ldwi) -> T0..T5 in 6 cycles; Gra & Rin & Zlowout in T5; back in T0 on cycle 7.
- ldw; mem_ready low for 2 cycles in T6 -> Read & MDRin held 3 cycles; T7 asserts MDRout & Gra & Rin once; total 10 cycles.
- stw; mem_ready high -> T6 asserts Gra & Rout & MDRin; T7 asserts Write; Read never high after T1.
- ir_opcode=11010 (halt) after fetch -> HALT at T3+1; halted=1; all controls 0; run_in toggling has no effect.
- mem_ready held low in T1 -> fault=1 exactly MEM_TIMEOUT cycles after T1 entry; ir_opcode=11111 gives one illegal_op pulse and a return to T0.
- clear pulsed low during T6 of ldw -> all outputs 0 immediately, tstate=0; restart with run_in fetches normally.
